mem_stage_ctrl: RTL and testbench

Sequencer for the core's memory stage. It sits directly upstream of the byte-lane memory interface. It accepts one load/store request at a time from the execute stage and holds rd/wr until the interface reports `complete`, tolerating bus inhibit stalls. On the following cycle it samples the interface's registered `malign`, `fault` and extended read data. It then issues exactly one retirement: a writeback, a store completion, or a precise exception.

---
 rtl/mem_stage_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage sequencer between the execute stage and the
// byte-lane memory interface. It takes one load/store request at a time,
// holds rd/wr until the interface completes (or a timeout expires), samples
// the registered interface flags the following cycle and retires the request
// as a writeback, a store completion or a precise exception.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake from execute
//   req_store, req_funct3,
//   req_address, req_wdata,
//   req_rd_idx                      request fields
//   flush                           pipeline flush
//   mem_address, mem_sign_size,
//   mem_rd, mem_wr, mem_wdata       to the memory interface
//   mem_rdata, mem_complete,
//   mem_malign, mem_fault           from the memory interface
//   wb_valid, wb_rd_idx, wb_data    load writeback
//   done                            retirement pulse
//   exc_valid, exc_cause, exc_tval  precise exception
module mem_stage_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_address,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd_idx,
  input  logic            flush,
  output logic [XLEN-1:0] mem_address,
  output logic [2:0]      mem_sign_size,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_complete,
  input  logic            mem_malign,
  input  logic            mem_fault,
  output logic            wb_valid,
  output logic [4:0]      wb_rd_idx,
  output logic [XLEN-1:0] wb_data,
  output logic            done,
  output logic            exc_valid,
  output logic [3:0]      exc_cause,
  output logic [XLEN-1:0] exc_tval
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, next_state;
  logic            lat_store;
  logic [2:0]      lat_funct3;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [4:0]      lat_rd;
  logic [CW-1:0]   cnt;
  logic            timed_out;
  logic [4:0]      wb_rd_hold;
  logic [XLEN-1:0] wb_data_hold;
  logic [XLEN-1:0] tval_hold;

  logic accept;
  logic timeout_now;
  logic resp_exc;
  logic resp_wb;

  assign accept      = (state == IDLE) && req_valid && !flush;
  // The timeout cycle itself no longer drives rd/wr; complete is ignored there.
  assign timeout_now = (state == ISSUE) && (cnt == CNT_MAX);
  assign resp_exc    = (state == RESP) && (mem_malign || timed_out || mem_fault);
  assign resp_wb     = (state == RESP) && !resp_exc && !lat_store && (lat_rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_store    <= 1'b0;
      lat_funct3   <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_rd       <= '0;
      cnt          <= '0;
      timed_out    <= 1'b0;
      wb_rd_hold   <= '0;
      wb_data_hold <= '0;
      tval_hold    <= '0;
    end else begin
      if (accept) begin
        lat_store  <= req_store;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_address;
        lat_wdata  <= req_wdata;
        lat_rd     <= req_rd_idx;
        cnt        <= '0;
        timed_out  <= 1'b0;
      end
      if (state == ISSUE) begin
        if (timeout_now) timed_out <= 1'b1;
        else if (!mem_complete && !flush && cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
      if (resp_wb) begin
        wb_rd_hold   <= lat_rd;
        wb_data_hold <= mem_rdata;
      end
      if (resp_exc) tval_hold <= lat_addr;
    end
  end

  always_comb begin
    next_state    = state;
    req_ready     = 1'b0;
    mem_address   = '0;
    mem_sign_size = '0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    mem_wdata     = '0;
    wb_valid      = 1'b0;
    wb_rd_idx     = wb_rd_hold;
    wb_data       = wb_data_hold;
    done          = 1'b0;
    exc_valid     = 1'b0;
    exc_cause     = '0;
    exc_tval      = tval_hold;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (accept) next_state = ISSUE;
      end
      ISSUE: begin
        mem_address   = lat_addr;
        mem_sign_size = lat_funct3;
        mem_wdata     = lat_wdata;
        mem_rd        = !lat_store && !timeout_now;
        mem_wr        = lat_store && !timeout_now;
        // A completed access is committed, so complete outranks flush.
        if (timeout_now)       next_state = flush ? IDLE : RESP;
        else if (mem_complete) next_state = RESP;
        else if (flush)        next_state = IDLE;
      end
      RESP: begin
        done       = 1'b1;
        next_state = IDLE;
        if (resp_exc) begin
          exc_valid = 1'b1;
          // 4/5 load, 6/7 store; odd causes are access faults.
          exc_cause = {2'b01, lat_store, !mem_malign};
          exc_tval  = lat_addr;
        end else if (resp_wb) begin
          wb_valid  = 1'b1;
          wb_rd_idx = lat_rd;
          wb_data   = mem_rdata;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0, req_ready;
  logic            req_store = 1'b0;
  logic [2:0]      req_funct3 = '0;
  logic [XLEN-1:0] req_address = '0, req_wdata = '0;
  logic [4:0]      req_rd_idx = '0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] mem_address, mem_wdata;
  logic [2:0]      mem_sign_size;
  logic            mem_rd, mem_wr;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            mem_complete = 1'b0, mem_malign = 1'b0, mem_fault = 1'b0;
  logic            wb_valid, done, exc_valid;
  logic [4:0]      wb_rd_idx;
  logic [XLEN-1:0] wb_data, exc_tval;
  logic [3:0]      exc_cause;

  mem_stage_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_address(req_address),
    .req_wdata(req_wdata), .req_rd_idx(req_rd_idx), .flush(flush),
    .mem_address(mem_address), .mem_sign_size(mem_sign_size), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_complete(mem_complete), .mem_malign(mem_malign), .mem_fault(mem_fault),
    .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data), .done(done),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding request, how long it has been on
  // the bus, and whether it is waiting to retire.
  bit              m_busy = 0;      // request accepted, not yet finished on the bus
  bit              m_retire = 0;    // retirement due this cycle
  int              m_age = 0;       // bus cycles already spent without completion
  bit              m_forced = 0;
  logic            m_store = 0;
  logic [2:0]      m_f3 = '0;
  logic [XLEN-1:0] m_addr = '0, m_wdata = '0;
  logic [4:0]      m_rd = '0;
  logic [4:0]      h_idx = '0;
  logic [XLEN-1:0] h_data = '0, h_tval = '0;

  function automatic int cause_of(input logic st, input logic mal, input logic flt, input bit forced);
    if (mal) return st ? 6 : 4;
    if (forced || flt) return st ? 7 : 5;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_retire = 0; m_age = 0; m_forced = 0;
      h_idx = '0; h_data = '0; h_tval = '0;
    end else if (m_retire) begin
      if (cause_of(m_store, mem_malign, mem_fault, m_forced) != 0) h_tval = m_addr;
      else if (!m_store && m_rd != 0) begin h_idx = m_rd; h_data = mem_rdata; end
      m_retire = 0;
    end else if (m_busy) begin
      if (m_age == TO) begin m_busy = 0; m_retire = !flush; m_forced = 1; end
      else if (mem_complete) begin m_busy = 0; m_retire = 1; end
      else if (flush) m_busy = 0;
      else m_age = m_age + 1;
    end else if (req_valid && !flush) begin
      m_busy = 1; m_age = 0; m_forced = 0;
      m_store = req_store; m_f3 = req_funct3; m_addr = req_address;
      m_wdata = req_wdata; m_rd = req_rd_idx;
    end
  end

  bit cmp_en = 1;
  logic            e_ready, e_rd, e_wr, e_wbv, e_done, e_exc;
  logic [XLEN-1:0] e_addr, e_wdata, e_data, e_tval;
  logic [2:0]      e_ss;
  logic [4:0]      e_idx;
  logic [3:0]      e_cause;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_ready = rst_n && !m_busy && !m_retire;
      e_addr = '0; e_ss = '0; e_wdata = '0; e_rd = 0; e_wr = 0;
      e_wbv = 0; e_done = 0; e_exc = 0; e_cause = '0;
      e_idx = h_idx; e_data = h_data; e_tval = h_tval;
      if (m_busy) begin
        e_addr = m_addr; e_ss = m_f3; e_wdata = m_wdata;
        e_rd = !m_store && (m_age != TO);
        e_wr = m_store && (m_age != TO);
      end
      if (m_retire) begin
        e_done = 1;
        e_cause = 4'(cause_of(m_store, mem_malign, mem_fault, m_forced));
        if (e_cause != 0) begin e_exc = 1; e_tval = m_addr; end
        else if (!m_store && m_rd != 0) begin e_wbv = 1; e_idx = m_rd; e_data = mem_rdata; end
      end
      chk("req_ready", req_ready, e_ready);
      chk("mem_address", mem_address, e_addr);
      chk("mem_sign_size", mem_sign_size, e_ss);
      chk("mem_rd", mem_rd, e_rd);
      chk("mem_wr", mem_wr, e_wr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("wb_valid", wb_valid, e_wbv);
      chk("wb_rd_idx", wb_rd_idx, e_idx);
      chk("wb_data", wb_data, e_data);
      chk("done", done, e_done);
      chk("exc_valid", exc_valid, e_exc);
      chk("exc_cause", exc_cause, e_cause);
      chk("exc_tval", exc_tval, e_tval);
    end
  end

  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1; req_store = st; req_funct3 = f3; req_address = a;
    req_wdata = wd; req_rd_idx = rd;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  // Observes one request from the cycle after its handshake until done.
  // mem_complete is raised in bus cycle stall+1.
  int              r_lat, r_wr, r_rd;
  logic            r_wbv, r_exc;
  logic [3:0]      r_cause;
  logic [31:0]     r_data, r_tval;
  logic [4:0]      r_idx;

  task automatic run(input int stall);
    r_lat = -1; r_wr = 0; r_rd = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (mem_wr) r_wr++;
      if (mem_rd) r_rd++;
      if (done) begin
        r_lat = cyc; r_wbv = wb_valid; r_exc = exc_valid; r_cause = exc_cause;
        r_data = wb_data; r_tval = exc_tval; r_idx = wb_rd_idx;
      end
      @(posedge clk); #1;
      mem_complete = (cyc >= stall);
      if (r_lat >= 0) begin mem_complete = 0; break; end
    end
  endtask

  int n_done;

  initial begin
    #12;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_mem_rd", mem_rd, 0);
    chk("reset_done", done, 0);
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    chk("post_reset_ready", req_ready, 1);
    @(posedge clk); #1;

    // Load word, immediate completion.
    mem_rdata = 32'hDEADBEEF; mem_complete = 1;
    send(0, 3'b010, 32'h100, 0, 5'd5);
    run(0);
    chk("lw_latency", r_lat, 2);
    chk("lw_wb_valid", r_wbv, 1);
    chk("lw_wb_idx", r_idx, 5);
    chk("lw_wb_data", r_data, 32'hDEADBEEF);
    chk("lw_exc", r_exc, 0);
    chk("lw_rd_cycles", r_rd, 1);

    // Store half, three stall cycles.
    mem_complete = 0;
    send(1, 3'b001, 32'h202, 32'h1234, 5'd0);
    run(3);
    chk("sh_latency", r_lat, 5);
    chk("sh_wr_cycles", r_wr, 4);
    chk("sh_wb_valid", r_wbv, 0);
    chk("sh_exc", r_exc, 0);

    // Misaligned load with fault also set: misaligned wins.
    mem_malign = 1; mem_fault = 1; mem_complete = 1;
    send(0, 3'b010, 32'h101, 0, 5'd9);
    run(0);
    chk("mal_exc", r_exc, 1);
    chk("mal_cause", r_cause, 4);
    chk("mal_tval", r_tval, 32'h101);
    chk("mal_wb_valid", r_wbv, 0);
    mem_malign = 0; mem_fault = 0;

    // Store never completes: timeout.
    mem_complete = 0;
    send(1, 3'b010, 32'h300, 32'hAA, 5'd0);
    run(1000);
    chk("to_wr_cycles", r_wr, 4);
    chk("to_latency", r_lat, 6);
    chk("to_exc", r_exc, 1);
    chk("to_cause", r_cause, 7);
    chk("to_tval", r_tval, 32'h300);

    // Flush during ISSUE: abandoned, no retirement.
    send(0, 3'b010, 32'h400, 0, 5'd3);
    @(negedge clk);
    chk("fl_rd_before", mem_rd, 1);
    @(posedge clk); #1; flush = 1;
    @(posedge clk); #1; flush = 0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("fl_no_done", n_done, 0);
    chk("fl_ready", req_ready, 1);
    @(posedge clk); #1;

    // Flush together with complete: retires normally; flush in RESP ignored.
    mem_rdata = 32'h0BADF00D; mem_complete = 1;
    send(0, 3'b010, 32'h500, 0, 5'd7);
    flush = 1;
    run(0);
    flush = 0;
    chk("flc_latency", r_lat, 2);
    chk("flc_wb_valid", r_wbv, 1);
    chk("flc_wb_data", r_data, 32'h0BADF00D);
    chk("flc_wb_idx", r_idx, 7);

    // Load to x0: done without writeback.
    mem_complete = 1;
    send(0, 3'b100, 32'h600, 0, 5'd0);
    run(0);
    chk("x0_latency", r_lat, 2);
    chk("x0_wb_valid", r_wbv, 0);
    chk("x0_exc", r_exc, 0);

    // Handshake while flush is high is ignored.
    flush = 1; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0; flush = 0;
    @(negedge clk);
    chk("flhs_ready", req_ready, 1);
    chk("flhs_rd", mem_rd, 0);
    @(posedge clk); #1;

    // Reset in the middle of ISSUE.
    mem_complete = 0;
    send(0, 3'b010, 32'h700, 0, 5'd4);
    @(negedge clk);
    chk("rst_rd_before", mem_rd, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_rd_async", mem_rd, 0);
    chk("rst_ready_low", req_ready, 0);
    @(posedge clk); #1; rst_n = 1;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("rst_no_done", n_done, 0);
    chk("rst_ready", req_ready, 1);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
